// File: rtl/ib_bm_pkg.sv
// Shared types and field widths for the bus-master request arbiter.
// Optional per-channel grant statistics are enabled by IB_BM_ARBITER_STATS_EN.
package ib_bm_pkg;

  localparam int unsigned GADDR_W   = 64;
  localparam int unsigned LADDR_W   = 32;
  localparam int unsigned LEN_W     = 12;
  localparam int unsigned TYPE_W    = 2;
  // Widest upstream tag ({channel, channel tag}) the request struct can carry.
  localparam int unsigned TAG_MAX_W = 16;
  // Outstanding counters must hold MAX_OUTSTANDING up to 15.
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned STAT_W    = 32;

  typedef enum logic [TYPE_W-1:0] {
    BmL2g = 2'd0,
    BmG2l = 2'd1
  } bm_type_e;

  typedef struct packed {
    logic [GADDR_W-1:0]   gaddr;
    logic [LADDR_W-1:0]   laddr;
    logic [LEN_W-1:0]     len;
    logic [TYPE_W-1:0]    xfer_type;
    logic [TAG_MAX_W-1:0] tag;
  } bm_req_t;

  typedef enum logic [0:0] {
    StIdle,
    StIssue
  } arb_state_e;

endpackage

// File: rtl/ib_bm_arbiter_if.sv
// Endpoint bus-master port: one request channel plus the completion return path.
interface ib_bm_arbiter_if
  import ib_bm_pkg::*;
#(
  parameter int unsigned TAG_WIDTH = 5,
  parameter int unsigned CH_BITS   = 2
);

  logic                         bm_req;
  logic                         bm_ack;
  logic [GADDR_W-1:0]           bm_gaddr;
  logic [LADDR_W-1:0]           bm_laddr;
  logic [LEN_W-1:0]             bm_len;
  logic [TYPE_W-1:0]            bm_type;
  logic [TAG_WIDTH+CH_BITS-1:0] bm_tag;
  logic                         bm_op_done;
  logic [TAG_WIDTH+CH_BITS-1:0] bm_op_tag;

  modport master (
    output bm_req, bm_gaddr, bm_laddr, bm_len, bm_type, bm_tag,
    input  bm_ack, bm_op_done, bm_op_tag
  );

  modport slave (
    input  bm_req, bm_gaddr, bm_laddr, bm_len, bm_type, bm_tag,
    output bm_ack, bm_op_done, bm_op_tag
  );

endinterface

// File: rtl/ib_bm_rr_arbiter.sv
// Round-robin one-hot selector: the search starts at ptr_i and wraps to channel 0.
module ib_bm_rr_arbiter #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CH_BITS  = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req_i,
  input  logic [CH_BITS-1:0]  ptr_i,
  input  logic                en_i,
  output logic [CHANNELS-1:0] grant_o,
  output logic [CH_BITS-1:0]  idx_o,
  output logic                valid_o
);

  int unsigned cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      cand = 32'(ptr_i) + k;
      if (cand >= CHANNELS) begin
        cand = cand - CHANNELS;
      end
      if (en_i && !valid_o && req_i[cand]) begin
        valid_o       = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = CH_BITS'(cand);
      end
    end
  end

endmodule

// File: rtl/ib_bm_arbiter.sv
// Multiplexes per-channel bus-master requests onto one endpoint port with per-channel
// outstanding limits. Define IB_BM_ARBITER_STATS_EN to add per-channel grant counters.
module ib_bm_arbiter
  import ib_bm_pkg::*;
#(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned TAG_WIDTH       = 5,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CHANNELS-1:0]           ch_req,
  input  logic [CHANNELS*GADDR_W-1:0]   ch_gaddr,
  input  logic [CHANNELS*LADDR_W-1:0]   ch_laddr,
  input  logic [CHANNELS*LEN_W-1:0]     ch_len,
  input  logic [CHANNELS*TYPE_W-1:0]    ch_type,
  input  logic [CHANNELS*TAG_WIDTH-1:0] ch_tag,
  output logic [CHANNELS-1:0]           ch_ack,
  output logic [CHANNELS-1:0]           ch_op_done,
  output logic [TAG_WIDTH-1:0]          ch_op_tag,
  output logic                          err_underflow,
`ifdef IB_BM_ARBITER_STATS_EN
  output logic [CHANNELS*STAT_W-1:0]    stat_grants,
`endif
  ib_bm_arbiter_if.master               bm
);

  localparam int unsigned CH_BITS  = $clog2(CHANNELS);
  localparam int unsigned BM_TAG_W = TAG_WIDTH + CH_BITS;

  arb_state_e           state_q, state_d;
  logic [CH_BITS-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     cnt_q [CHANNELS];
  logic [CNT_W-1:0]     cnt_d [CHANNELS];
  bm_req_t              req_q, req_d;
  logic                 bm_req_q, bm_req_d;
  logic [CHANNELS-1:0]  op_done_q, op_done_d;
  logic [TAG_WIDTH-1:0] op_tag_q, op_tag_d;
  logic                 err_q, err_d;

  logic [CHANNELS-1:0]  eligible;
  logic [CHANNELS-1:0]  grant;
  logic [CH_BITS-1:0]   gidx;
  logic                 gvalid;
  logic                 arb_en;

  logic [CH_BITS-1:0]   op_ch;
  logic                 op_in_range;
  logic                 dec_valid;

  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      eligible[i] = ch_req[i] && (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
    end
  end

  // Gating with rst_n keeps ch_ack low while reset is held, not just after it.
  assign arb_en = (state_q == StIdle) && rst_n;

  ib_bm_rr_arbiter #(
    .CHANNELS (CHANNELS),
    .CH_BITS  (CH_BITS)
  ) u_rr (
    .req_i   (eligible),
    .ptr_i   (rr_ptr_q),
    .en_i    (arb_en),
    .grant_o (grant),
    .idx_o   (gidx),
    .valid_o (gvalid)
  );

  assign ch_ack = grant;

  assign op_ch       = bm.bm_op_tag[BM_TAG_W-1 -: CH_BITS];
  assign op_in_range = 32'(op_ch) < CHANNELS;
  assign dec_valid   = bm.bm_op_done && op_in_range && (cnt_q[op_ch] != '0);

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    req_d     = req_q;
    bm_req_d  = bm_req_q;
    cnt_d     = cnt_q;
    op_done_d = '0;
    op_tag_d  = op_tag_q;
    err_d     = err_q;

    unique case (state_q)
      StIdle: begin
        if (gvalid) begin
          state_d         = StIssue;
          bm_req_d        = 1'b1;
          req_d.gaddr     = ch_gaddr[gidx*GADDR_W +: GADDR_W];
          req_d.laddr     = ch_laddr[gidx*LADDR_W +: LADDR_W];
          req_d.len       = ch_len[gidx*LEN_W +: LEN_W];
          req_d.xfer_type = ch_type[gidx*TYPE_W +: TYPE_W];
          req_d.tag       = TAG_MAX_W'({gidx, ch_tag[gidx*TAG_WIDTH +: TAG_WIDTH]});
          cnt_d[gidx]     = cnt_q[gidx] + CNT_W'(1);
          rr_ptr_d        = (32'(gidx) == CHANNELS - 1) ? '0 : gidx + CH_BITS'(1);
        end
      end
      StIssue: begin
        if (bm.bm_ack) begin
          state_d  = StIdle;
          bm_req_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Applied after the grant increment so a same-edge grant and completion cancel out.
    if (bm.bm_op_done) begin
      if (dec_valid) begin
        cnt_d[op_ch]     = cnt_d[op_ch] - CNT_W'(1);
        op_done_d[op_ch] = 1'b1;
        op_tag_d         = bm.bm_op_tag[TAG_WIDTH-1:0];
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      req_q     <= '0;
      bm_req_q  <= 1'b0;
      op_done_q <= '0;
      op_tag_q  <= '0;
      err_q     <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      req_q     <= req_d;
      bm_req_q  <= bm_req_d;
      op_done_q <= op_done_d;
      op_tag_q  <= op_tag_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bm.bm_req   = bm_req_q;
  assign bm.bm_gaddr = req_q.gaddr;
  assign bm.bm_laddr = req_q.laddr;
  assign bm.bm_len   = req_q.len;
  assign bm.bm_type  = req_q.xfer_type;
  assign bm.bm_tag   = req_q.tag[BM_TAG_W-1:0];

  generate
    if (BM_TAG_W < TAG_MAX_W) begin : g_tag_spare
      logic unused_tag_bits;
      assign unused_tag_bits = ^req_q.tag[TAG_MAX_W-1:BM_TAG_W];
    end
  endgenerate

  assign ch_op_done    = op_done_q;
  assign ch_op_tag     = op_tag_q;
  assign err_underflow = err_q;

`ifdef IB_BM_ARBITER_STATS_EN
  logic [STAT_W-1:0] stat_q [CHANNELS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        stat_q[i] <= '0;
      end
    end else if (gvalid && (stat_q[gidx] != '1)) begin
      stat_q[gidx] <= stat_q[gidx] + STAT_W'(1);
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_stat
    assign stat_grants[gi*STAT_W +: STAT_W] = stat_q[gi];
  end
`endif

endmodule
